apb_completer: RTL and testbench

APB_COMPLETER -- requirements
Module: apb_completer

---
 rtl/apb_pkg.sv | 26 ++
 rtl/apb_completer_mem.sv | 31 +++
 rtl/apb_completer.sv | 96 +++++++++
 tb/tb_apb_completer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB completer slice.
package apb_pkg;

  localparam int APB_ADDR_W    = 8;
  localparam int APB_DATA_W    = 8;
  localparam int MEM_DEPTH_DEF = 64;
  localparam int CNT_W         = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } apb_state_e;

  // Fields captured in the setup cycle and held for the whole transfer.
  typedef struct packed {
    logic [APB_ADDR_W-1:0] addr;
    logic                  write;
    logic [APB_DATA_W-1:0] wdata;
  } apb_req_t;

  function automatic logic addr_in_range(input logic [APB_ADDR_W-1:0] addr, input int depth);
    return 32'(addr) < 32'(depth);
  endfunction

endpackage

// File: rtl/apb_completer_mem.sv
// Byte storage: one register row per location, synchronous write and clear, combinational read.
module apb_completer_mem
  import apb_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  we,
  input  logic [APB_ADDR_W-1:0] waddr,
  input  logic [APB_DATA_W-1:0] wdata,
  input  logic [APB_ADDR_W-1:0] raddr,
  output logic [APB_DATA_W-1:0] rdata
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [APB_DATA_W-1:0] mem [MEM_DEPTH];

  for (genvar i = 0; i < MEM_DEPTH; i++) begin : g_row
    localparam logic [APB_ADDR_W-1:0] ROW = APB_ADDR_W'(i);
    always_ff @(posedge PCLK) begin
      if (!PRESETn)                  mem[i] <= '0;
      else if (we && waddr == ROW)   mem[i] <= wdata;
    end
  end

  // Out-of-range reads never index the array.
  assign rdata = addr_in_range(raddr, MEM_DEPTH) ? mem[raddr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/apb_completer.sv
// APB completer: setup/wait/response FSM with programmable wait states and error checks.
module apb_completer
  import apb_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int MEM_DEPTH   = MEM_DEPTH_DEF
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [APB_ADDR_W-1:0] PADDR,
  input  logic [APB_DATA_W-1:0] PWDATA,
  output logic [APB_DATA_W-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam logic [CNT_W-1:0] WS = CNT_W'(WAIT_STATES);

  apb_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  apb_req_t              req_q, req_d;
  logic                  mis_q, mis_d;
  logic                  acc_mis, err_now, rdy, mem_we;
  logic [APB_DATA_W-1:0] mem_rdata;

  // The current access cycle counts too, so a mismatch seen only in RESP still flags.
  assign acc_mis = PSEL && PENABLE && (PADDR != req_q.addr || PWRITE != req_q.write);
  assign err_now = !addr_in_range(req_q.addr, MEM_DEPTH) || mis_q || acc_mis;

  assign rdy     = (state_q == ST_RESP) && PSEL;
  assign mem_we  = rdy && req_q.write && !err_now;
  assign PREADY  = rdy;
  assign PSLVERR = rdy && err_now;
  assign PRDATA  = (rdy && !req_q.write && !err_now) ? mem_rdata : '0;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    mis_d   = mis_q;
    unique case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          req_d = '{addr: PADDR, write: PWRITE, wdata: PWDATA};
          mis_d = 1'b0;
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WS;
          end
        end
      end
      ST_WAIT: begin
        if (!PSEL || !PENABLE) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          mis_d = mis_q || acc_mis;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  apb_completer_mem #(.MEM_DEPTH(MEM_DEPTH)) u_mem (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .we      (mem_we),
    .waddr   (req_q.addr),
    .wdata   (req_q.wdata),
    .raddr   (req_q.addr),
    .rdata   (mem_rdata)
  );

endmodule

// File: tb/tb_apb_completer.sv
// Bench: two completers (2 and 0 wait states), table-driven transfers plus corner sequences.
module tb_apb_completer;

  logic       PCLK;
  logic       PRESETn;
  logic       psel[2], penable[2], pwrite[2];
  logic [7:0] paddr[2], pwdata[2], prdata[2];
  logic       pready[2], pslverr[2];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         d;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rd;
    logic       err;
    int         waits;
  } vec_t;

  typedef struct {
    logic [7:0] rd;
    logic       err;
    int         waits;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[15];

  apb_completer #(.WAIT_STATES(2), .MEM_DEPTH(64)) u_w2 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(penable[0]),
    .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
  );

  apb_completer #(.WAIT_STATES(0), .MEM_DEPTH(64)) u_w0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(penable[1]),
    .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One transfer: setup now, access phase with PADDR=a_acc; samples on falling edges.
  task automatic xfer(input int d, input logic wr, input logic [7:0] a, input logic [7:0] a_acc,
                      input logic [7:0] wd, output int waits, output logic [7:0] rd,
                      output logic er, output logic got, output logic leak);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
    @(posedge PCLK); #1;
    penable[d] = 1'b1; paddr[d] = a_acc;
    waits = 0; got = 1'b0; rd = '0; er = 1'b0; leak = 1'b0;
    for (int c = 0; c < 16 && !got; c++) begin
      @(negedge PCLK);
      if (pready[d]) begin
        got = 1'b1; rd = prdata[d]; er = pslverr[d];
      end else begin
        waits++;
        if (prdata[d] != 8'h00 || pslverr[d]) leak = 1'b1;
      end
      @(posedge PCLK); #1;
    end
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic run(input int d, input logic wr, input logic [7:0] a, input logic [7:0] a_acc,
                     input logic [7:0] wd, input logic [7:0] e_rd, input logic e_err,
                     input int e_w, input string nm);
    exp_t e;
    int w;
    logic [7:0] rd;
    logic er, got, leak;
    sb.push_back('{e_rd, e_err, e_w});
    xfer(d, wr, a, a_acc, wd, w, rd, er, got, leak);
    e = sb.pop_front();
    chk({nm, "_pready_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({nm, "_wait_cycles"}, 32'(w), 32'(e.waits));
      chk({nm, "_prdata"}, 32'(rd), 32'(e.rd));
      chk({nm, "_pslverr"}, 32'(er), 32'(e.err));
      chk({nm, "_idle_outputs_zero"}, 32'(leak), 32'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
    end
    PRESETn = 1'b0;

    //               d  wr    addr   wdata  rd     err   waits
    tbl[0]  = '{0, 1'b1, 8'h00, 8'h5C, 8'h00, 1'b0, 2};
    tbl[1]  = '{0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0, 2};
    tbl[2]  = '{0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 2};
    tbl[3]  = '{0, 1'b1, 8'h3F, 8'hC3, 8'h00, 1'b0, 2};
    tbl[4]  = '{0, 1'b0, 8'h3F, 8'h00, 8'hC3, 1'b0, 2};
    tbl[5]  = '{0, 1'b1, 8'h40, 8'h77, 8'h00, 1'b1, 2};
    tbl[6]  = '{0, 1'b0, 8'h40, 8'h00, 8'h00, 1'b1, 2};
    tbl[7]  = '{0, 1'b0, 8'h00, 8'h00, 8'h5C, 1'b0, 2};
    tbl[8]  = '{0, 1'b1, 8'hFF, 8'h01, 8'h00, 1'b1, 2};
    tbl[9]  = '{1, 1'b1, 8'h00, 8'h11, 8'h00, 1'b0, 0};
    tbl[10] = '{1, 1'b1, 8'h3F, 8'h22, 8'h00, 1'b0, 0};
    tbl[11] = '{1, 1'b0, 8'h00, 8'h00, 8'h11, 1'b0, 0};
    tbl[12] = '{1, 1'b0, 8'h3F, 8'h00, 8'h22, 1'b0, 0};
    tbl[13] = '{0, 1'b1, 8'h02, 8'h33, 8'h00, 1'b0, 2};
    tbl[14] = '{0, 1'b0, 8'h02, 8'h00, 8'h33, 1'b0, 2};

    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_pready_%0d", d), 32'(pready[d]), 32'd0);
      chk($sformatf("reset_pslverr_%0d", d), 32'(pslverr[d]), 32'd0);
      chk($sformatf("reset_prdata_%0d", d), 32'(prdata[d]), 32'd0);
    end
    @(posedge PCLK); #1;
    PRESETn = 1'b1;

    for (int i = 0; i < 15; i++)
      run(tbl[i].d, tbl[i].wr, tbl[i].addr, tbl[i].addr, tbl[i].wdata,
          tbl[i].rd, tbl[i].err, tbl[i].waits, $sformatf("vec%0d", i));

    // Address changes between setup and access phase.
    run(0, 1'b1, 8'h05, 8'h06, 8'h99, 8'h00, 1'b1, 2, "addr_change_w2");
    run(0, 1'b0, 8'h05, 8'h05, 8'h00, 8'h00, 1'b0, 2, "addr_change_rd05");
    run(0, 1'b0, 8'h06, 8'h06, 8'h00, 8'h00, 1'b0, 2, "addr_change_rd06");
    run(1, 1'b1, 8'h05, 8'h06, 8'h99, 8'h00, 1'b1, 0, "addr_change_w0");
    run(1, 1'b0, 8'h05, 8'h05, 8'h00, 8'h00, 1'b0, 0, "addr_change_w0_rd05");

    // PSEL dropped in the first wait cycle.
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h08; pwdata[0] = 8'h5A;
    @(posedge PCLK); #1;
    psel[0] = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge PCLK);
      if (pready[0]) seen++;
      @(posedge PCLK); #1;
    end
    chk("abort_psel_no_pready", 32'(seen), 32'd0);
    run(0, 1'b0, 8'h08, 8'h08, 8'h00, 8'h00, 1'b0, 2, "abort_psel_rd08");

    // PENABLE low in a wait cycle also aborts.
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h09; pwdata[0] = 8'h6B;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    psel[0] = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge PCLK);
      if (pready[0]) seen++;
      @(posedge PCLK); #1;
    end
    chk("abort_penable_no_pready", 32'(seen), 32'd0);
    run(0, 1'b0, 8'h09, 8'h09, 8'h00, 8'h00, 1'b0, 2, "abort_penable_rd09");

    // Access-phase signalling without a setup is ignored.
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 8'h0A; pwdata[0] = 8'hEE;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge PCLK);
      if (pready[0]) seen++;
      @(posedge PCLK); #1;
    end
    psel[0] = 1'b0; penable[0] = 1'b0;
    chk("idle_penable_ignored", 32'(seen), 32'd0);
    run(0, 1'b0, 8'h0A, 8'h0A, 8'h00, 8'h00, 1'b0, 2, "idle_penable_rd0a");

    // Reset in the middle of a wait phase.
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h02; pwdata[0] = 8'h44;
    @(posedge PCLK); #1;
    penable[0] = 1'b1; PRESETn = 1'b0;
    @(posedge PCLK); #1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(negedge PCLK);
    chk("midreset_pready", 32'(pready[0]), 32'd0);
    chk("midreset_pslverr", 32'(pslverr[0]), 32'd0);
    chk("midreset_prdata", 32'(prdata[0]), 32'd0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    run(0, 1'b0, 8'h02, 8'h02, 8'h00, 8'h00, 1'b0, 2, "midreset_rd02");
    run(1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 0, "midreset_w0_rd00");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
